// File: rtl/gcd_scheduler.sv
// Round-robin front end that time-shares one subtractive GCD datapath among N requesters.
// Define GCD_WDT_EN to abort jobs that exceed MAX_ITER subtract steps (reported via rsp_err).
module gcd_scheduler #(
  parameter int N        = 4,
  parameter int W        = 16,
  parameter int IDW      = 2,
  parameter int MAX_ITER = 65535
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] op_a,
  input  logic [N*W-1:0] op_b,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic [W-1:0]   dp_data,
  output logic           ld_a,
  output logic           ld_b,
  output logic           sel1,
  output logic           sel2,
  output logic           sel_in,
  input  logic           lt,
  input  logic           gt,
  input  logic           eq,
  input  logic [W-1:0]   dp_a,
  output logic           rsp_valid,
  output logic [IDW-1:0] rsp_id,
  output logic [W-1:0]   rsp_gcd,
  output logic           rsp_err
);

  if (N < 2 || N > 8 || IDW < $clog2(N) || MAX_ITER < 1) begin : g_bad_params
    $error("gcd_scheduler: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE, CAPTURE, LOAD_A, LOAD_B, COMPARE, SUB_A, SUB_B, DONE
  } state_t;

  state_t         state, nxt;
  logic [IDW-1:0] rr, rr_nxt, cap_id, pick;
  logic [W-1:0]   cap_a, cap_b, pick_a, pick_b, gcd_nxt;
  logic [N-1:0]   rot;
  logic           found;
  int unsigned    pos, pos1;

`ifdef GCD_WDT_EN
  logic [31:0] wdt_cnt;
  logic        err_nxt;
`endif

  // Rotate requests so bit 0 is the rr pointer; the first set bit wins.
  always_comb begin
    rot    = N'({req, req} >> rr);
    found  = 1'b0;
    pos    = 0;
    pick   = '0;
    pick_a = '0;
    pick_b = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pos   = 32'(rr) + i;
        if (pos >= N) pos = pos - N;
      end
    end
    pick = IDW'(pos);
    for (int unsigned j = 0; j < N; j++) begin
      if (IDW'(j) == pick) begin
        pick_a = op_a[j*W +: W];
        pick_b = op_b[j*W +: W];
      end
    end
    pos1 = pos + 1;
    if (pos1 >= N) pos1 = 0;
    rr_nxt = IDW'(pos1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt     = state;
    gcd_nxt = '0;
`ifdef GCD_WDT_EN
    err_nxt = 1'b0;
`endif
    case (state)
      IDLE:    if (found) nxt = CAPTURE;
      CAPTURE: begin
        if (cap_a == '0 || cap_b == '0) begin
          nxt     = DONE;
          gcd_nxt = (cap_a == '0) ? cap_b : cap_a;
        end else begin
          nxt = LOAD_A;
        end
      end
      LOAD_A:  nxt = LOAD_B;
      LOAD_B:  nxt = COMPARE;
      COMPARE: begin
        // Illegal flag combinations fall through to the eq path.
        if (gt && !lt && !eq)      nxt = SUB_A;
        else if (lt && !gt && !eq) nxt = SUB_B;
        else begin
          nxt     = DONE;
          gcd_nxt = dp_a;
        end
`ifdef GCD_WDT_EN
        if (wdt_cnt == 32'(MAX_ITER) && !eq) begin
          nxt     = DONE;
          gcd_nxt = '0;
          err_nxt = 1'b1;
        end
`endif
      end
      SUB_A:   nxt = COMPARE;
      SUB_B:   nxt = COMPARE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr     <= '0;
      cap_id <= '0;
      cap_a  <= '0;
      cap_b  <= '0;
    end else if (state == IDLE && found) begin
      rr     <= rr_nxt;
      cap_id <= pick;
      cap_a  <= pick_a;
      cap_b  <= pick_b;
    end
  end

`ifdef GCD_WDT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 wdt_cnt <= '0;
    else if (state == CAPTURE)                  wdt_cnt <= '0;
    else if (state == SUB_A || state == SUB_B)  wdt_cnt <= wdt_cnt + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_err <= 1'b0;
    else        rsp_err <= (nxt == DONE) ? err_nxt : 1'b0;
  end
`else
  assign rsp_err = 1'b0;
`endif

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      busy      <= 1'b0;
      dp_data   <= '0;
      ld_a      <= 1'b0;
      ld_b      <= 1'b0;
      sel1      <= 1'b0;
      sel2      <= 1'b0;
      sel_in    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_gcd   <= '0;
    end else begin
      gnt       <= (nxt == CAPTURE) ? (N'(1) << pick) : '0;
      busy      <= (nxt != IDLE);
      dp_data   <= (nxt == LOAD_A) ? cap_a : (nxt == LOAD_B) ? cap_b : '0;
      ld_a      <= (nxt == LOAD_A) || (nxt == SUB_A);
      ld_b      <= (nxt == LOAD_B) || (nxt == SUB_B);
      sel1      <= (nxt == SUB_A);
      sel2      <= (nxt == SUB_B);
      sel_in    <= (nxt == LOAD_A) || (nxt == LOAD_B);
      rsp_valid <= (nxt == DONE);
      if (nxt == DONE) begin
        rsp_id  <= cap_id;
        rsp_gcd <= gcd_nxt;
      end
    end
  end

endmodule

// File: tb/tb_gcd_scheduler.sv
// Directed bench for gcd_scheduler with a behavioural subtractive GCD datapath attached.
// Expectations follow GCD_WDT_EN when the macro is defined.
module tb_gcd_scheduler;
  localparam int N = 4;
  localparam int W = 16;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] op_a = '0;
  logic [N*W-1:0] op_b = '0;
  logic [N-1:0]   gnt;
  logic           busy, ld_a, ld_b, sel1, sel2, sel_in;
  logic [W-1:0]   dp_data, dp_a, rsp_gcd;
  logic           lt, gt, eq, rsp_valid, rsp_err;
  logic [IDW-1:0] rsp_id;

  logic [W-1:0]   reg_a = '0;
  logic [W-1:0]   reg_b = '0;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] hist;
  int          ld_cnt;

  gcd_scheduler #(.N(N), .W(W), .IDW(IDW), .MAX_ITER(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .busy(busy), .dp_data(dp_data), .ld_a(ld_a), .ld_b(ld_b),
    .sel1(sel1), .sel2(sel2), .sel_in(sel_in), .lt(lt), .gt(gt), .eq(eq),
    .dp_a(dp_a), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_gcd(rsp_gcd),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  assign lt   = reg_a < reg_b;
  assign gt   = reg_a > reg_b;
  assign eq   = reg_a == reg_b;
  assign dp_a = reg_a;

  always @(posedge clk) begin
    if (ld_a) reg_a <= sel_in ? dp_data : (sel1 ? reg_a - reg_b : reg_b - reg_a);
    if (ld_b) reg_b <= sel_in ? dp_data : (sel2 ? reg_b - reg_a : reg_a - reg_b);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic set_op(input int i, input int a, input int b);
    op_a[i*W +: W] = W'(a);
    op_b[i*W +: W] = W'(b);
  endtask

  // Waits for a grant, then follows the job to its response; latency counted from the gnt cycle.
  task automatic job(input string tag, input logic [N-1:0] gnt_exp, input int id_exp,
                     input int gcd_exp, input int lat_exp, input bit err_exp, input bit drop);
    int n;
    n = 0;
    while (gnt == '0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".gnt"}, 32'(gnt), 32'(gnt_exp));
    if (drop) req = '0;
    hist = '0;
    ld_cnt = 0;
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      if (n == 1) check({tag, ".gnt_pulse"}, 32'(gnt), 0);
      if (ld_a || ld_b) ld_cnt++;
      if (rsp_valid) break;
      hist = {hist[29:0], ld_a, ld_b};
    end
    check({tag, ".latency"}, n, lat_exp);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 1);
    check({tag, ".rsp_id"}, 32'(rsp_id), id_exp);
    check({tag, ".rsp_gcd"}, 32'(rsp_gcd), gcd_exp);
    check({tag, ".rsp_err"}, 32'(rsp_err), 32'(err_exp));
  endtask

  initial begin
    int n;
    #12;
    check("reset.ctrl", 32'({gnt, busy, ld_a, ld_b, sel1, sel2, sel_in, rsp_valid, rsp_err}), 0);
    check("reset.data", 32'({dp_data, rsp_gcd}), 0);
    check("reset.id", 32'(rsp_id), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // gcd(143,78)=13 over 6 subtracts: A,B,A,A,A,A
    set_op(0, 143, 78);
    req = 4'b0001;
    job("g143_78", 4'b0001, 0, 13, 16, 1'b0, 1'b1);
    check("g143_78.ld_trace", hist, 32'h2484_8888);
    check("g143_78.ld_count", ld_cnt, 8);

    set_op(0, 48, 48);
    req = 4'b0001;
    job("g48_48", 4'b0001, 0, 48, 4, 1'b0, 1'b1);
    check("g48_48.ld_count", ld_cnt, 2);

    set_op(2, 0, 35);
    req = 4'b0100;
    job("g0_35", 4'b0100, 2, 35, 1, 1'b0, 1'b1);
    check("g0_35.ld_count", ld_cnt, 0);
    repeat (3) @(negedge clk);
    check("hold.rsp_gcd", 32'(rsp_gcd), 35);
    check("hold.rsp_valid", 32'(rsp_valid), 0);
    check("idle.busy", 32'(busy), 0);

    set_op(2, 0, 0);
    req = 4'b0100;
    job("g0_0", 4'b0100, 2, 0, 1, 1'b0, 1'b1);
    check("g0_0.ld_count", ld_cnt, 0);

    // Fresh reset so round robin starts from requester 0 with all four pending.
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, 12, 18);
    req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    job("rr0", 4'b0001, 0, 6, 8, 1'b0, 1'b0);
    job("rr1", 4'b0010, 1, 6, 8, 1'b0, 1'b0);
    job("rr2", 4'b0100, 2, 6, 8, 1'b0, 1'b0);
    job("rr3", 4'b1000, 3, 6, 8, 1'b0, 1'b0);
    job("rr4", 4'b0001, 0, 6, 8, 1'b0, 1'b1);

    // Reset in SUB_A drops the job; held req1 wins afterwards.
    set_op(0, 143, 78);
    set_op(1, 20, 5);
    req = 4'b0001;
    n = 0;
    while (gnt == '0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("midrst.gnt", 32'(gnt), 32'(4'b0001));
    req = 4'b0010;
    repeat (4) @(negedge clk);
    check("midrst.in_sub_a", 32'({ld_a, sel1, sel2, sel_in}), 32'(4'b1100));
    rst_n = 1'b0;
    #1;
    check("midrst.ctrl", 32'({gnt, busy, ld_a, ld_b, sel1, sel2, sel_in, rsp_valid, rsp_err}), 0);
    check("midrst.data", 32'({dp_data, rsp_gcd}), 0);
    check("midrst.id", 32'(rsp_id), 0);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || busy) n++;
    end
    check("midrst.quiet", n, 0);
    rst_n = 1'b1;
    job("after_rst", 4'b0010, 1, 5, 10, 1'b0, 1'b1);

    set_op(0, 100, 1);
    req = 4'b0001;
`ifdef GCD_WDT_EN
    job("wdt", 4'b0001, 0, 0, 12, 1'b1, 1'b1);
`else
    job("wdt", 4'b0001, 0, 1, 202, 1'b0, 1'b1);
`endif
    @(negedge clk);
    check("wdt.err_pulse", 32'(rsp_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gcd_scheduler.md
Name: gcd_scheduler

Overview:
- Round-robin scheduler that shares one subtractive GCD datapath between N requesters.
- Arbitrates requests and captures the winner's operand pair.
- Sequences the datapath control lines (ld_a, ld_b, sel1, sel2, sel_in) through load, compare and subtract.
- Returns the result to the winner tagged with its index. Sits between requester ports and the existing GCD datapath; replaces the single-user controller.

Parameters:
- N, 4, number of requesters (2..8)
- W, 16, operand/result width; matches datapath bus width
- IDW, 2, width of rsp_id; must be >= clog2(N)
- MAX_ITER, 65535, subtract-step limit (used only with GCD_WDT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N  per-requester request level
- op_a  in  N*W  operand A, requester i at bits [i*W +: W]
- op_b  in  N*W  operand B, same packing
- gnt  out  N  one-hot grant, one-cycle pulse; operands captured on this cycle
- busy  out  1  high in every state except IDLE
- dp_data  out  W  to datapath data_in
- ld_a  out  1  load datapath A register
- ld_b  out  1  load datapath B register
- sel1  out  1  1: subtractor minuend=A, subtrahend=B
- sel2  out  1  1: subtractor minuend=B, subtrahend=A
- sel_in  out  1  1: datapath register input = data_in, 0 = subtractor output
- lt  in  1  datapath comparator A<B
- gt  in  1  datapath comparator A>B
- eq  in  1  datapath comparator A==B
- dp_a  in  W  datapath A register value
- rsp_valid  out  1  one-cycle result pulse
- rsp_id  out  IDW  index of served requester
- rsp_gcd  out  W  result
- rsp_err  out  1  watchdog abort flag, valid with rsp_valid

Behaviour:
- All outputs registered, Moore-style, decoded from state.
- Reset (async, any state, mid-operation included):
  - state=IDLE, rr pointer=0, captured operands=0.
  - gnt, ld_a, ld_b, sel1, sel2, sel_in, rsp_valid, rsp_err all 0; rsp_id, rsp_gcd, dp_data=0. An in-flight job is dropped with no response.
- States: IDLE, CAPTURE, LOAD_A, LOAD_B, COMPARE, SUB_A, SUB_B, DONE.
- IDLE, any req set:
  - Pick the first set bit searching upward from rr pointer, wrapping at N-1.
  - Capture op_a/op_b and index; go to CAPTURE.
  - rr pointer = winner+1 mod N.
- CAPTURE: gnt[winner]=1 for this cycle only.
  - If either captured operand is 0: go to DONE, rsp_gcd = other operand (0 if both 0).
  - Else go to LOAD_A.
- LOAD_A: dp_data=cap_a, sel_in=1, ld_a=1.
- LOAD_B: dp_data=cap_b, sel_in=1, ld_b=1.
- COMPARE: no loads; datapath flags are valid this cycle.
  - eq: go to DONE, rsp_gcd=dp_a.
  - gt: go to SUB_A.
  - lt: go to SUB_B.
  - No flag or multiple flags set (illegal): treated as eq.
- SUB_A: sel1=1, sel2=0, sel_in=0, ld_a=1 (A<=A-B); go to COMPARE.
- SUB_B: sel1=0, sel2=1, sel_in=0, ld_b=1 (B<=B-A); go to COMPARE.
- DONE: rsp_valid=1, rsp_id=winner, rsp_gcd held from entry; go to IDLE.
- rsp_id/rsp_gcd hold their last value until the next DONE.
- Latency, gnt at cycle t:
  - zero operand: rsp_valid at t+1.
  - otherwise: rsp_valid at t+4+2k, where k = number of subtract steps.
- Requests that arrive while busy wait; req is level, sampled only in IDLE.
- A requester may drop req after gnt; re-asserting req before rsp_valid queues a new job.
- At most one job in flight. Back-to-back jobs: IDLE occupies one cycle between DONE and the next CAPTURE.

Optional Feature:
- Macro GCD_WDT_EN.
- Defined:
  - Counter resets in CAPTURE and increments on each SUB_A/SUB_B.
  - If COMPARE is entered with count==MAX_ITER and eq=0: go to DONE with rsp_err=1, rsp_gcd=0.
- Undefined: no counter; rsp_err tied 0; MAX_ITER unused.

Test Plan:
- N=4, req=0001, op_a0=143, op_b0=78 -> gnt=0001 at t; 6 subtract steps; rsp_valid at t+16 with rsp_id=0, rsp_gcd=13; ld_a/ld_b pulse sequence matches state trace.
- req0 op=(48,48) -> one COMPARE, no SUB; rsp_valid at t+4, rsp_gcd=48.
- req2 op=(0,35) -> no ld_a/ld_b asserted; rsp_valid at t+1, rsp_id=2, rsp_gcd=35. Repeat with (0,0): rsp_gcd=0.
- All four req held high, every op=(12,18) -> grants in order 0001,0010,0100,1000,0001; each rsp_gcd=6 with matching rsp_id.
- Assert rst_n=0 mid-job during SUB_A -> all outputs 0 immediately, state IDLE, no rsp_valid. After release, held req1 is granted first (rr=0 search, req0 low).
- GCD_WDT_EN, MAX_ITER=4, op=(100,1) -> after 4 SUB_A steps, rsp_valid with rsp_err=1, rsp_gcd=0. Without the macro the same stimulus gives rsp_gcd=1, rsp_err=0.
